// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM states,
// register byte offsets within the 16-byte window, and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_BAUDDIV = 4'h8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: combinational read of the head entry, 1-cycle write-to-visible latency.
// A push while full is accepted only together with a pop; otherwise it is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Bus-mapped 8N1 UART transmitter; reads are combinational, a pushed byte starts its frame one edge later.
// Stores to a full FIFO with no same-cycle pop are dropped and flagged in the sticky overflow bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e   state;
    logic [7:0]    shreg;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [15:0]   bauddiv;
    logic          overflow;

    logic [3:0]    off;
    logic          wr_txdata;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   cnt_ext;
    logic [31:0]   status_word;
    logic          baud_zero;
    logic          unused_bits;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = {addr[3:2], 2'b00};
    assign wr_txdata = we && sel && (off == UART_TXDATA);
    assign baud_zero = (baud_cnt == 16'd0);
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_zero));
    assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);
    assign cnt_ext   = 32'(fifo_count);
    assign unused_bits = ^{addr[1:0], wdata[31:16], cnt_ext[31:4]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        status_word                        = '0;
        status_word[STAT_BUSY]             = (state != IDLE);
        status_word[STAT_FULL]             = fifo_full;
        status_word[STAT_EMPTY]            = fifo_empty;
        status_word[STAT_OVF]              = overflow;
        status_word[STAT_CNT_LSB +: 4]     = cnt_ext[3:0];
    end

    always_comb begin
        rdata = '0;
        if (sel && re) begin
            case (off)
                UART_STATUS:  rdata = status_word;
                UART_BAUDDIV: rdata = {16'h0, bauddiv};
                default:      rdata = '0;
            endcase
        end
    end

    // Driven from state so reset forces the line high without waiting for a clock.
    always_comb begin
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bauddiv  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else if (we && sel) begin
            if (off == UART_BAUDDIV) begin
                bauddiv <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
            if (off == UART_STATUS) begin
                overflow <= 1'b0;
            end else if (wr_txdata && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            div_q    <= DEFAULT_DIV;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (fifo_pop) begin
            // Divisor is sampled per frame so mid-frame BAUDDIV writes wait for the next one.
            state    <= START;
            shreg    <= fifo_dat;
            div_q    <= bauddiv;
            baud_cnt <= bauddiv - 16'd1;
            bit_cnt  <= '0;
        end else if (state != IDLE) begin
            if (!baud_zero) begin
                baud_cnt <= baud_cnt - 16'd1;
            end else begin
                baud_cnt <= div_q - 16'd1;
                case (state)
                    START: state <= DATA;
                    DATA: begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, directly downstream of the ALU. The ALU result (load/store effective address) drives `addr`; store data drives `wdata`. Software pushes bytes into a small FIFO, and the block serialises them as 8N1 frames, LSB first, on `tx` at a programmable bit period. Status and divisor registers are readable combinationally, so single-cycle loads complete in the same cycle.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: base of the 16-byte register window; `addr[31:4]` must match `BASE_ADDR[31:4]`.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of two, ≥2.
- `DEFAULT_DIV`, default 16'd868: reset value of BAUDDIV (100 MHz / 115200).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address from the ALU result.
- `wdata`  in  32  store data.
- `we`  in  1  store strobe, valid for one cycle.
- `re`  in  1  load strobe.
- `rdata`  out  32  combinational read data; 0 when not selected or `re`=0.
- `sel`  out  1  `addr` is in the window; the core uses it for its load mux.
- `tx`  out  1  serial line; idles high.

## Operation
- Register map (word offsets from base; `addr[1:0]` ignored):
  - 0x0 TXDATA: write pushes `wdata[7:0]`. Reads return 0.
  - 0x4 STATUS: read-only fields except bit 3.
    - bit0 busy (state≠IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky; any write to 0x4 clears it)
    - bits[7:4] FIFO count
    - rest 0
  - 0x8 BAUDDIV: rw, bits[15:0]. A written value of 0 is stored as 1.
  - 0xC: reserved. Reads 0, writes ignored.
- Push when `we`, `sel`, offset 0x0, and the FIFO is not full, evaluated after any same-cycle pop.
  - Full with a same-cycle pop: the push is accepted and the count is unchanged.
  - Full with no pop: the byte is dropped and overflow is set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop into `shreg`, latch BAUDDIV into `div_q`, clear the bit counter, go to START.
  - START: `tx`=0 for `div_q` cycles, then go to DATA.
  - DATA: `tx`=`shreg[0]` for `div_q` cycles per bit, shift right each bit, 8 bits, then go to STOP.
  - STOP: `tx`=1 for `div_q` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- A BAUDDIV write mid-frame does not affect the current frame; it applies from the next frame.
- Baud counter: 16-bit, counts `div_q`-1 down to 0. The bit boundary is at 0.

## Timing
- Reset values:
  - `tx`=1, state IDLE, FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV.
  - `rdata`=0 and `sel`=0 unless driven by the inputs.
- `rdata` and `sel` are purely combinational from `addr` and `re` in the same cycle.
- Write at edge N (block idle, FIFO empty):
  - FIFO non-empty after N.
  - Pop and START at edge N+1.
  - `tx` falls after N+1.
- Frame length is exactly 10×`div_q` cycles. Back-to-back frames have no gap.
- STATUS busy reads 1 from edge N+1 until the edge ending STOP of the last frame.
- `rst_n` asserted mid-frame: `tx` goes high immediately (asynchronously) and the FIFO contents are discarded.

## Structure
- Package `uart_pkg`:
  - `uart_state_e` enum (IDLE, START, DATA, STOP)
  - register offset constants `UART_TXDATA`/`UART_STATUS`/`UART_BAUDDIV`
  - STATUS bit-index localparams
- One sub-module, `sync_fifo`:
  - parameters: width 8, depth `FIFO_DEPTH`
  - ports: push, pop, full, empty, count
  - same-cycle push and pop allowed when full.
- The top level holds the address decode, registers, FSM, and baud counter.

## Test plan
- Reset, then read 0x8000_0004 -> `rdata`=0x04 (empty), `tx`=1; read 0x8000_0008 -> 868.
- Write BAUDDIV=4, write TXDATA 0xA5 -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; busy clears after the stop bit.
- BAUDDIV=2, push 6 bytes back-to-back -> 1 byte in flight plus 4 queued, 1 dropped; overflow=1; frames contiguous with no idle gap. A write to 0x4 clears overflow.
- FIFO full with a push at the same edge as a STOP-end pop -> byte accepted, count stays 4, overflow stays 0.
- Write BAUDDIV=8 during a DIV=2 frame -> current frame stays 2 cycles/bit; the next frame uses 8. Writing 0 reads back 1.
- Assert `rst_n` mid-DATA -> `tx`=1 at once; after release, STATUS=0x04 and no further frames are sent.
